// File: rtl/tdo_mux_chain_if.sv
// TDO mux bus: TAP/IR side signals in, registered pin-driver signals out.
interface tdo_mux_chain_if #(
  parameter int IR_W   = 4,
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [3:0]            tap_state;
  logic [IR_W-1:0]       ir;
  logic                  ir_tdo;
  logic [NUM_CH-1:0]     ch_tdo;
  logic [NUM_CH*IR_W-1:0]  ch_opcode;
  logic [NUM_CH*CNT_W-1:0] ch_len;
  logic [NUM_CH-1:0]     ch_secure;
  logic                  sec_unlock;
  logic                  tdo;
  logic                  tdo_en;
  logic                  sel_valid;
  logic [CH_W-1:0]       sel_ch;
  logic                  overrun;
  logic                  sec_viol;

  modport master (
    output tap_state, ir, ir_tdo, ch_tdo, ch_opcode, ch_len, ch_secure, sec_unlock,
    input  tdo, tdo_en, sel_valid, sel_ch, overrun, sec_viol
  );

  modport slave (
    input  tap_state, ir, ir_tdo, ch_tdo, ch_opcode, ch_len, ch_secure, sec_unlock,
    output tdo, tdo_en, sel_valid, sel_ch, overrun, sec_viol
  );
endinterface

// File: rtl/tdo_mux_chain.sv
// Registered TDO output stage: IR bit or opcode-selected DR channel, with shift-length limit.
// Optional secure-channel blocking when TDO_SEC_LOCK_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | previous sampled TAP state was not a shift
// ST_IR   | previous sampled TAP state was Shift-IR
// ST_DR   | previous sampled TAP state was Shift-DR
module tdo_mux_chain #(
  parameter int          IR_W     = 4,
  parameter int          NUM_CH   = 8,
  parameter int          CNT_W    = 8,
  parameter int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter logic [3:0]  SHIFT_IR = 4'b1010,
  parameter logic [3:0]  SHIFT_DR = 4'b0010
) (
  input  logic            tck,
  input  logic            rst,
  tdo_mux_chain_if.slave  bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_IR, ST_DR} state_t;

  state_t           state, state_n;
  logic             tdo_q, tdo_n;
  logic             en_q, en_n;
  logic             sv_q, sv_n;
  logic [CH_W-1:0]  sc_q, sc_n;
  logic             ov_q, ov_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             blk_q, blk_n;
  logic             viol_n;

  logic             dec_hit;
  logic [CH_W-1:0]  dec_ch;
  logic             entry;
  logic [CH_W-1:0]  cur_ch;
  logic             cur_valid;
  logic             cur_blk;
  logic [CNT_W-1:0] cur_k;
  logic [CNT_W-1:0] cur_len;

  // Iterate downward so the lowest matching channel overwrites the others.
  always_comb begin
    dec_hit = 1'b0;
    dec_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.ir == bus.ch_opcode[i*IR_W +: IR_W]) begin
        dec_hit = 1'b1;
        dec_ch  = CH_W'(i);
      end
    end
  end

  assign entry     = (bus.tap_state == SHIFT_DR) && (state != ST_DR);
  assign cur_ch    = entry ? dec_ch  : sc_q;
  assign cur_valid = entry ? dec_hit : sv_q;
  assign cur_k     = entry ? '0 : cnt_q;
  assign cur_len   = bus.ch_len[cur_ch*CNT_W +: CNT_W];

`ifdef TDO_SEC_LOCK_EN
  logic viol_q;
  assign cur_blk      = entry ? (dec_hit && bus.ch_secure[dec_ch] && !bus.sec_unlock) : blk_q;
  assign bus.sec_viol = viol_q;
  always_ff @(posedge tck) begin
    if (rst) viol_q <= 1'b0;
    else     viol_q <= viol_n;
  end
`else
  logic unused_sec;
  assign unused_sec   = ^{bus.ch_secure, bus.sec_unlock, viol_n};
  assign cur_blk      = 1'b0;
  assign bus.sec_viol = 1'b0;
`endif

  always_comb begin
    state_n = ST_IDLE;
    tdo_n   = 1'b0;
    en_n    = 1'b0;
    sv_n    = 1'b0;
    sc_n    = sc_q;
    ov_n    = ov_q;
    cnt_n   = '0;
    blk_n   = blk_q;
    viol_n  = 1'b0;
    if (bus.tap_state == SHIFT_DR) begin
      state_n = ST_DR;
      en_n    = 1'b1;
      sv_n    = cur_valid;
      sc_n    = cur_ch;
      blk_n   = cur_blk;
      viol_n  = entry && cur_blk;
      if (cur_valid && !cur_blk && ((cur_len == '0) || (cur_k < cur_len)))
        tdo_n = bus.ch_tdo[cur_ch];
      cnt_n = (cur_k == '1) ? cur_k : cur_k + 1'b1;
      if (entry)
        ov_n = 1'b0;
      if (cur_valid && (cur_len != '0) && (cur_k == cur_len))
        ov_n = 1'b1;
    end else if (bus.tap_state == SHIFT_IR) begin
      state_n = ST_IR;
      tdo_n   = bus.ir_tdo;
      en_n    = 1'b1;
    end
  end

  always_ff @(posedge tck) begin
    if (rst) begin
      state <= ST_IDLE;
      tdo_q <= 1'b0;
      en_q  <= 1'b0;
      sv_q  <= 1'b0;
      sc_q  <= '0;
      ov_q  <= 1'b0;
      cnt_q <= '0;
      blk_q <= 1'b0;
    end else begin
      state <= state_n;
      tdo_q <= tdo_n;
      en_q  <= en_n;
      sv_q  <= sv_n;
      sc_q  <= sc_n;
      ov_q  <= ov_n;
      cnt_q <= cnt_n;
      blk_q <= blk_n;
    end
  end

  assign bus.tdo       = tdo_q;
  assign bus.tdo_en    = en_q;
  assign bus.sel_valid = sv_q;
  assign bus.sel_ch    = sc_q;
  assign bus.overrun   = ov_q;
endmodule

// File: tb/tb_tdo_mux_chain.sv
// Directed bench for tdo_mux_chain; expectations queued per cycle and checked after each edge.
module tb_tdo_mux_chain;
  localparam logic [3:0] SHIFT_IR = 4'b1010;
  localparam logic [3:0] SHIFT_DR = 4'b0010;
  localparam logic [3:0] IDLE_ST  = 4'b1100;
`ifdef TDO_SEC_LOCK_EN
  localparam bit SEC_LOCK = 1'b1;
`else
  localparam bit SEC_LOCK = 1'b0;
`endif

  typedef struct packed {
    logic       tdo;
    logic       en;
    logic       sv;
    logic [2:0] sc;
    logic       ov;
    logic       viol;
    logic       sc_x;
  } exp_t;

  logic tck = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t  sb[$];
  string tags[$];
  logic [9:0] pat = 10'b1011001110;

  tdo_mux_chain_if bus();
  tdo_mux_chain dut (.tck(tck), .rst(rst), .bus(bus));

  always #5 tck = ~tck;

  task automatic set_ch(input int ch, input logic b);
    logic [7:0] m;
    m = 8'b1 << ch;
    bus.ch_tdo = b ? m : ~m;
  endtask

  task automatic cyc(input logic t, input logic en, input logic sv, input logic [2:0] sc,
                     input logic ov, input logic vi, input bit scx, input string tag);
    exp_t e;
    string tg;
    logic [7:0] obs, expv;
    sb.push_back('{tdo: t, en: en, sv: sv, sc: sc, ov: ov, viol: vi, sc_x: scx});
    tags.push_back(tag);
    @(posedge tck);
    #1;
    e    = sb.pop_front();
    tg   = tags.pop_front();
    expv = {e.tdo, e.en, e.sv, e.sc, e.ov, e.viol};
    obs  = {bus.tdo, bus.tdo_en, bus.sel_valid, bus.sel_ch, bus.overrun, bus.sec_viol};
    if (e.sc_x) obs[4:2] = e.sc;
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed {tdo,en,sv,sc,ov,viol}=%b expected %b", tg, obs, expv);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.tap_state  = SHIFT_IR;
    bus.ir         = 4'h0;
    bus.ir_tdo     = 1'b1;
    bus.ch_tdo     = '0;
    bus.ch_len     = '0;
    bus.ch_secure  = 8'b0000_1000;
    bus.sec_unlock = 1'b0;
    for (int i = 0; i < 8; i++) bus.ch_opcode[i*4 +: 4] = 4'(8 + i);
    bus.ch_opcode[1*4 +: 4] = 4'b0001;
    bus.ch_opcode[5*4 +: 4] = 4'b0001;
    bus.ch_opcode[2*4 +: 4] = 4'b0110;

    cyc(0, 0, 0, 0, 0, 0, 0, "reset_0");
    cyc(0, 0, 0, 0, 0, 0, 0, "reset_1");
    rst = 1'b0;
    cyc(1, 1, 0, 0, 0, 0, 0, "ir_first");
    bus.tap_state = IDLE_ST;
    cyc(0, 0, 0, 0, 0, 0, 0, "idle_a");

    // unlimited channel 2 burst
    bus.ir = 4'b0110;
    bus.tap_state = SHIFT_DR;
    for (int k = 0; k < 10; k++) begin
      set_ch(2, pat[k]);
      cyc(pat[k], 1, 1, 2, 0, 0, 0, $sformatf("unlim_k%0d", k));
    end
    bus.tap_state = IDLE_ST;
    cyc(0, 0, 0, 2, 0, 0, 0, "idle_b");

    // CH_LEN=4, 8-bit burst: over-shift gating and sticky overrun
    bus.ch_len[2*8 +: 8] = 8'd4;
    bus.tap_state = SHIFT_DR;
    for (int k = 0; k < 8; k++) begin
      set_ch(2, ~pat[k]);
      cyc((k < 4) ? ~pat[k] : 1'b0, 1, 1, 2, (k >= 4), 0, 0, $sformatf("len4_k%0d", k));
    end
    bus.tap_state = IDLE_ST;
    cyc(0, 0, 0, 2, 1, 0, 0, "ovr_hold");
    bus.tap_state = SHIFT_DR;
    set_ch(2, 1'b1);
    cyc(1, 1, 1, 2, 0, 0, 0, "ovr_clear");
    bus.tap_state = IDLE_ST;
    cyc(0, 0, 0, 2, 0, 0, 0, "idle_c");

    // lowest index wins; Shift-IR straight into Shift-DR; IR change mid-burst ignored
    bus.ir = 4'b0001;
    bus.ir_tdo = 1'b0;
    bus.tap_state = SHIFT_IR;
    cyc(0, 1, 0, 2, 0, 0, 0, "ir_zero");
    bus.tap_state = SHIFT_DR;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) bus.ir = 4'b0111;
      set_ch(1, pat[k+2]);
      cyc(pat[k+2], 1, 1, 1, 0, 0, 0, $sformatf("prio_k%0d", k));
    end
    bus.tap_state = IDLE_ST;
    cyc(0, 0, 0, 1, 0, 0, 0, "idle_d");

    // no match: enabled, data forced low, no selection
    bus.tap_state = SHIFT_DR;
    bus.ch_tdo = 8'hFF;
    for (int k = 0; k < 3; k++)
      cyc(0, 1, 0, 0, 0, 0, 1, $sformatf("nomatch_k%0d", k));
    bus.tap_state = IDLE_ST;
    cyc(0, 0, 0, 0, 0, 0, 1, "idle_e");

    // secure channel 3, locked then unlocked
    bus.ir = 4'hB;
    bus.tap_state = SHIFT_DR;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) bus.sec_unlock = 1'b1;
      set_ch(3, pat[k]);
      cyc(SEC_LOCK ? 1'b0 : pat[k], 1, 1, 3, 0, SEC_LOCK && (k == 0), 0,
          $sformatf("sec_lock_k%0d", k));
    end
    bus.tap_state = IDLE_ST;
    cyc(0, 0, 0, 3, 0, 0, 0, "idle_f");
    bus.tap_state = SHIFT_DR;
    for (int k = 0; k < 4; k++) begin
      set_ch(3, pat[k+4]);
      cyc(pat[k+4], 1, 1, 3, 0, 0, 0, $sformatf("sec_open_k%0d", k));
    end
    bus.sec_unlock = 1'b0;
    bus.tap_state = IDLE_ST;
    cyc(0, 0, 0, 3, 0, 0, 0, "idle_g");

    // reset at burst bit 3, then full budget again
    bus.ir = 4'b0110;
    bus.tap_state = SHIFT_DR;
    for (int k = 0; k < 3; k++) begin
      set_ch(2, pat[k+1]);
      cyc(pat[k+1], 1, 1, 2, 0, 0, 0, $sformatf("pre_rst_k%0d", k));
    end
    rst = 1'b1;
    set_ch(2, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, "rst_mid");
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_ch(2, pat[k+3]);
      cyc((k < 4) ? pat[k+3] : 1'b0, 1, 1, 2, (k >= 4), 0, 0, $sformatf("post_rst_k%0d", k));
    end
    bus.tap_state = IDLE_ST;
    cyc(0, 0, 0, 2, 1, 0, 0, "idle_h");

    // CH_LEN=1 boundary
    bus.ch_len[2*8 +: 8] = 8'd1;
    bus.tap_state = SHIFT_DR;
    set_ch(2, 1'b1);
    cyc(1, 1, 1, 2, 0, 0, 0, "len1_k0");
    cyc(0, 1, 1, 2, 1, 0, 0, "len1_k1");
    cyc(0, 1, 1, 2, 1, 0, 0, "len1_k2");
    bus.tap_state = IDLE_ST;
    cyc(0, 0, 0, 2, 1, 0, 0, "idle_i");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
